regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (reg_write/rd/rd_data) between NREQ writeback sources
//  (ALU, load unit, mul/div). Each source uses a valid/ready handshake.

---
 rtl/wb_arb_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared defaults, types and round-robin pick function for the writeback arbiter
package wb_arb_pkg;

    localparam int NREQ_DEF   = 3;
    localparam int DW_DEF     = 16;
    localparam int AW_DEF     = 4;
    localparam int PERF_W_DEF = 16;
    localparam int R0_IDX     = 0;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef struct packed {
        logic             grant;
        logic [IDX_W-1:0] winner;
    } rr_pick_t;

    // Walks from ptr+1 around the ring; iterating backwards lets the nearest eligible index overwrite the rest.
    function automatic rr_pick_t rr_next(
        input logic [IDX_W-1:0]   ptr,
        input logic [MAX_REQ-1:0] eligible,
        input int                 nreq
    );
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (eligible[idx]) begin
                    pick.grant  = 1'b1;
                    pick.winner = IDX_W'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - NREQ-way round-robin picker holding the last-winner pointer
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] eligible,
    output logic            grant_valid,
    output logic [NREQ-1:0] grant_onehot
);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [MAX_REQ-1:0] elig_pad;
    rr_pick_t           pick;

    always_comb begin
        elig_pad           = '0;
        elig_pad[NREQ-1:0] = eligible;
        pick               = rr_next(ptr_q, elig_pad, NREQ);
        grant_valid        = pick.grant;
        for (int i = 0; i < NREQ; i++) begin
            grant_onehot[i] = pick.grant && (pick.winner == IDX_W'(i));
        end
        ptr_d = pick.grant ? pick.winner : ptr_q;
    end

    // Reset pointer at the last slot so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter driving the regfile write port
// Optional perf counters enabled by defining WB_ARB_PERF_EN.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
`ifdef WB_ARB_PERF_EN
    , parameter int PERF_W = PERF_W_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_hold,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rf_reg_write,
    output logic [AW-1:0]      rf_rd,
    output logic [DW-1:0]      rf_rd_data
`ifdef WB_ARB_PERF_EN
    , output logic [NREQ*PERF_W-1:0] perf_grant_cnt
    , output logic [PERF_W-1:0]      perf_conflict
`endif
);

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] drop;
    logic [NREQ-1:0] grant_onehot;
    logic            grant_valid;
    logic [AW-1:0]   win_rd;
    logic [DW-1:0]   win_data;

    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [DW-1:0]   rf_data_q, rf_data_d;

    // R0 writes are acknowledged immediately but never compete for the write slot.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (req_rd[i*AW +: AW] != AW'(R0_IDX)) && !wb_hold;
            drop[i]     = req_valid[i] && (req_rd[i*AW +: AW] == AW'(R0_IDX)) && !wb_hold;
        end
    end

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .eligible    (eligible),
        .grant_valid (grant_valid),
        .grant_onehot(grant_onehot)
    );

    assign req_ready = rst_n ? (grant_onehot | drop) : '0;

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_onehot[i]) begin
                win_rd   = req_rd[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
        rf_we_d   = grant_valid;
        rf_rd_d   = grant_valid ? win_rd : rf_rd_q;
        rf_data_d = grant_valid ? win_data : rf_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_reg_write = rf_we_q;
    assign rf_rd        = rf_rd_q;
    assign rf_rd_data   = rf_data_q;

`ifdef WB_ARB_PERF_EN
    logic [NREQ*PERF_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [PERF_W-1:0]      conflict_q, conflict_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_onehot[i] && (grant_cnt_q[i*PERF_W +: PERF_W] != {PERF_W{1'b1}})) begin
                grant_cnt_d[i*PERF_W +: PERF_W] = grant_cnt_q[i*PERF_W +: PERF_W] + 1'b1;
            end
        end
        conflict_d = conflict_q;
        if (($countones(eligible) >= 2) && (conflict_q != {PERF_W{1'b1}})) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            conflict_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            conflict_q  <= conflict_d;
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_conflict  = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int PERF_W = 16;

    logic               clk;
    logic               rst_n;
    logic               wb_hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic               rf_reg_write;
    logic [AW-1:0]      rf_rd;
    logic [DW-1:0]      rf_rd_data;
`ifdef WB_ARB_PERF_EN
    logic [NREQ*PERF_W-1:0] perf_grant_cnt;
    logic [PERF_W-1:0]      perf_conflict;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_hold     (wb_hold),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .rf_reg_write(rf_reg_write),
        .rf_rd       (rf_rd),
        .rf_rd_data  (rf_rd_data)
`ifdef WB_ARB_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt)
        , .perf_conflict (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_rd[i*AW +: AW]    = rd;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic all_valid();
        set_req(0, 1'b1, 4'd1, 16'h0011);
        set_req(1, 1'b1, 4'd2, 16'h0022);
        set_req(2, 1'b1, 4'd3, 16'h0033);
    endtask

    task automatic check_write(input string tag, input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        check({tag, "_we"}, 64'(rf_reg_write), 64'(we));
        check({tag, "_rd"}, 64'(rf_rd), 64'(rd));
        check({tag, "_data"}, 64'(rf_rd_data), 64'(d));
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        wb_hold   = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        all_valid();
        #12;
        check("rst_ready", 64'(req_ready), 64'b000);
        check_write("rst_out", 1'b0, 4'd0, 16'h0000);

        // Test 1: first grant goes to req0
        rst_n = 1'b1;
        #1;
        check("t1_ready", 64'(req_ready), 64'b001);
        tick();
        check_write("t1_out", 1'b1, 4'd1, 16'h0011);

        // Test 2: rotation continues 1,2,0,1,2,0
        for (int k = 0; k < 6; k++) begin
            w = (k + 1) % 3;
            check($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'(1 << w));
            tick();
            check_write($sformatf("t2_out_%0d", k), 1'b1, AW'(w + 1), DW'(16'h0011 * (w + 1)));
        end

        // Test 3: R5 write plus R0 drop in the same cycle (ptr=0)
        set_req(0, 1'b1, 4'd5, 16'hA5A5);
        set_req(1, 1'b1, 4'd0, 16'hBEEF);
        set_req(2, 1'b0, 4'd3, 16'h0033);
        #1;
        check("t3_ready", 64'(req_ready), 64'b011);
        tick();
        check_write("t3_out", 1'b1, 4'd5, 16'hA5A5);
        all_valid();
        #1;
        check("t3_next_ready", 64'(req_ready), 64'b010);
        tick();
        check_write("t3_next_out", 1'b1, 4'd2, 16'h0022);

        // Test 4: hold for 3 cycles, then resume after ptr=1
        wb_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t4_ready_%0d", k), 64'(req_ready), 64'b000);
            tick();
            check_write($sformatf("t4_out_%0d", k), 1'b0, 4'd2, 16'h0022);
        end
        wb_hold = 1'b0;
        #1;
        check("t4_resume_ready", 64'(req_ready), 64'b100);
        tick();
        check_write("t4_resume_out", 1'b1, 4'd3, 16'h0033);

        // Test 5: async reset while a write is on the port
        check("t5_ready", 64'(req_ready), 64'b001);
        tick();
        check_write("t5_pre", 1'b1, 4'd1, 16'h0011);
        #2;
        rst_n = 1'b0;
        #1;
        check_write("t5_async", 1'b0, 4'd0, 16'h0000);
        check("t5_rst_ready", 64'(req_ready), 64'b000);
        #3;
        rst_n = 1'b1;
        #1;
        check("t5_post_ready", 64'(req_ready), 64'b001);
        tick();
        check_write("t5_post_out", 1'b1, 4'd1, 16'h0011);

        // Drop only: acknowledged, no write, pointer stays at 0
        set_req(0, 1'b1, 4'd0, 16'h1234);
        set_req(1, 1'b0, 4'd2, 16'h0022);
        set_req(2, 1'b0, 4'd3, 16'h0033);
        #1;
        check("drop_ready", 64'(req_ready), 64'b001);
        tick();
        check_write("drop_out", 1'b0, 4'd1, 16'h0011);
        all_valid();
        #1;
        check("drop_after_ready", 64'(req_ready), 64'b010);
        tick();

`ifdef WB_ARB_PERF_EN
        // Test 6: req0+req1 contend for 10 cycles from reset
        rst_n = 1'b0;
        set_req(2, 1'b0, 4'd3, 16'h0033);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("t6_cnt0", 64'(perf_grant_cnt[0*PERF_W +: PERF_W]), 64'd5);
        check("t6_cnt1", 64'(perf_grant_cnt[1*PERF_W +: PERF_W]), 64'd5);
        check("t6_cnt2", 64'(perf_grant_cnt[2*PERF_W +: PERF_W]), 64'd0);
        check("t6_conflict", 64'(perf_conflict), 64'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
